wb_scoreboard: RTL
==================

Name: wb_scoreboard

Overview:
- Hazard scoreboard and issue controller for the three-stage RV32I pipeline.
- Tracks in-flight writes to the GPR write port and the four CSR write lanes. Stalls decode/issue on RAW and CSR hazards.
- Releases a tracked entry when the writeback stage commits it or when the instruction is squashed.
- Sits between decode (issue handshake) and writeback/EX-kill (retire/kill events).

Parameters:
- CNT_W, 2, width of each per-register in-flight counter; max outstanding writes per target = 2^CNT_W-1
- CSR_N, 4, number of CSR write lanes; matches width of csr_wen
- WB_BYPASS, 1, if 1 a commit in the same cycle releases the hazard for an issuing reader

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts the instruction (no hazard)
- issue_rs1 / issue_rs2  in  5  source GPR indices
- issue_rs1_used / issue_rs2_used  in  1  source actually read
- issue_rd  in  5  destination GPR
- issue_R_wen  in  1  instruction writes a GPR
- issue_csr_rmask  in  CSR_N  CSR lanes read
- issue_csr_wen  in  CSR_N  CSR lanes written
- wb_valid  in  1  writeback commit this cycle
- wb_R_wen  in  1  commit writes a GPR
- wb_rd  in  5  committed GPR index
- wb_csr_wen  in  CSR_N  committed CSR lanes
- kill_valid  in  1  squashed instruction this cycle (jump flush)
- kill_R_wen / kill_rd / kill_csr_wen  in  1/5/CSR_N  targets of the squashed instruction
- busy_mask  out  32  GPR pending bitmap; bit0 always 0
- csr_busy  out  CSR_N  CSR lane pending bitmap
- sb_err  out  1  sticky underflow/overflow flag

Behaviour:
- Reset (reset=0, async): all counters 0, busy_mask=0, csr_busy=0, sb_err=0. issue_ready is combinational and reads 1 with an idle input after reset.
- Issue fires when issue_valid & issue_ready. issue_ready is combinational from current counters and this cycle's release events. It never depends on issue_valid.
- GPR hazard: rsX_used & rsX!=0 & cnt[rsX]!=0. If WB_BYPASS=1 and cnt[rsX]==1 and the same cycle has a commit/kill releasing rsX, there is no hazard.
- CSR hazard: any bit of issue_csr_rmask with csr_cnt!=0, same bypass rule.
- Structural stall: issue_R_wen & rd!=0 & cnt[rd]==max with no release this cycle. The same applies per CSR lane written.
- x0 is never tracked. Writes, commits and kills to rd=0 are ignored.
- Counter update per register, registered on the next rising edge: next = cnt + inc - dec.
  - inc = issue fire targeting it.
  - dec = (wb_valid & wb_R_wen & wb_rd==r) + (kill_valid & kill_R_wen & kill_rd==r). Range 0..2.
  - Simultaneous inc and dec on the same register: net per formula, and no error.
- Underflow (dec exceeding cnt): clamp to 0 and set sb_err.
- Overflow past max (only possible if the stall rule is violated): saturate and set sb_err.
- sb_err clears only on reset.
- busy_mask[r] = (cnt[r]!=0), registered view of current state. csr_busy has the same meaning per lane.
- Latency: an issue at cycle t makes busy visible at t+1. A commit at t clears at t+1, or is bypassed at t when WB_BYPASS=1.
- Reset mid-operation clears all tracking immediately. The pipeline is flushed by the same reset.

Decomposition:
- Package wb_sb_pkg holds:
  - REG_IDX_W=5, NUM_GPR=32, CSR_N=4.
  - typedef sb_cnt_t (logic [CNT_W-1:0]).
  - CSR lane index constants: CSR_MSTATUS=0, CSR_MTVEC=1, CSR_MEPC=2, CSR_MCAUSE=3.
- Sub-module sb_counter: one saturating up/down counter with inc, dec[1:0], async active-low clear and an err pulse. It is instantiated 31 times for the GPRs and CSR_N times for the CSR lanes.
- Top level holds hazard compare, bypass and err aggregation.

Test Plan:
- Reset, then issue rd=5 R_wen=1 → cycle+1 busy_mask=0x20. Next issue rs1=5 used → issue_ready=0 until wb_valid wb_rd=5; with WB_BYPASS=1 ready=1 in that same commit cycle.
- Issue rd=0 R_wen=1, then rs1=0 used → busy_mask stays 0, issue_ready=1 throughout.
- Three issues to rd=7 without commit (CNT_W=2) → cnt=3, fourth issue rd=7 has issue_ready=0. Commit rd=7 in the same cycle → ready=1, cnt stays 3.
- Issue rd=9 then kill_valid kill_rd=9 → busy_mask[9]=0 next cycle, sb_err=0. A second wb commit rd=9 → sb_err=1, sticky.
- Issue csr_wen=4'b0100 (MEPC), then issue csr_rmask=4'b0100 → stalled. wb_csr_wen=4'b0100 → csr_busy=0 and the read issues.
- Assert reset low asynchronously with busy_mask=0x0000_0F00 mid-cycle → busy_mask, csr_busy, sb_err read 0 before the next clock edge.

Source files
------------

// File: rtl/wb_sb_pkg.sv
// Shared constants and types for the hazard scoreboard.
// No logic; sizes the GPR index, counter width and CSR lane numbering.
package wb_sb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_GPR   = 32;
  localparam int CSR_N     = 4;
  localparam int CNT_W     = 2;

  typedef logic [CNT_W-1:0] sb_cnt_t;

  localparam int CSR_MSTATUS = 0;
  localparam int CSR_MTVEC   = 1;
  localparam int CSR_MEPC    = 2;
  localparam int CSR_MCAUSE  = 3;
endpackage

// File: rtl/wb_scoreboard_if.sv
// Issue, retire and kill events plus hazard status between decode/writeback and the scoreboard.
// Pure wiring; issue_ready is combinational and independent of issue_valid.
interface wb_scoreboard_if;
  import wb_sb_pkg::*;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [REG_IDX_W-1:0] issue_rs1;
  logic [REG_IDX_W-1:0] issue_rs2;
  logic                 issue_rs1_used;
  logic                 issue_rs2_used;
  logic [REG_IDX_W-1:0] issue_rd;
  logic                 issue_R_wen;
  logic [CSR_N-1:0]     issue_csr_rmask;
  logic [CSR_N-1:0]     issue_csr_wen;
  logic                 wb_valid;
  logic                 wb_R_wen;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [CSR_N-1:0]     wb_csr_wen;
  logic                 kill_valid;
  logic                 kill_R_wen;
  logic [REG_IDX_W-1:0] kill_rd;
  logic [CSR_N-1:0]     kill_csr_wen;
  logic [NUM_GPR-1:0]   busy_mask;
  logic [CSR_N-1:0]     csr_busy;
  logic                 sb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_R_wen, issue_csr_rmask, issue_csr_wen,
           wb_valid, wb_R_wen, wb_rd, wb_csr_wen,
           kill_valid, kill_R_wen, kill_rd, kill_csr_wen,
    input  issue_ready, busy_mask, csr_busy, sb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_R_wen, issue_csr_rmask, issue_csr_wen,
           wb_valid, wb_R_wen, wb_rd, wb_csr_wen,
           kill_valid, kill_R_wen, kill_rd, kill_csr_wen,
    output issue_ready, busy_mask, csr_busy, sb_err
  );
endinterface

// File: rtl/wb_scoreboard_sb_counter.sv
// Saturating in-flight counter: +inc, -dec per cycle, clamps at 0 and max with a one-cycle err pulse.
// One-cycle update latency; no backpressure, the caller keeps inc from overflowing.
module sb_counter
  import wb_sb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic [1:0]   dec,
  output logic [W-1:0] cnt,
  output logic         err
);
  localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W+1:0] up, dec_w, diff;

  always_comb begin
    up    = {2'b00, cnt_q} + {{(W+1){1'b0}}, inc};
    dec_w = {{W{1'b0}}, dec};
    diff  = up - dec_w;
    cnt_d = diff[W-1:0];
    err   = 1'b0;
    if (up < dec_w) begin
      cnt_d = '0;
      err   = 1'b1;
    end else if (diff > MAX) begin
      cnt_d = '1;
      err   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/wb_scoreboard.sv
// RAW/CSR hazard scoreboard: per-target in-flight counters gate decode issue.
// Issue/commit visible one cycle later; issue_ready drops on hazard or a full counter.
module wb_scoreboard #(
  parameter int CNT_W     = 2,
  parameter int CSR_N     = 4,
  parameter int WB_BYPASS = 1
) (
  input logic            clk,
  input logic            rst_n,
  wb_scoreboard_if.slave sb
);
  localparam int NG = wb_sb_pkg::NUM_GPR;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] gpr_cnt [NG];
  logic [1:0]       gpr_dec [NG];
  logic [NG-1:0]    gpr_err;
  logic [CNT_W-1:0] csr_cnt [CSR_N];
  logic [1:0]       csr_dec [CSR_N];
  logic [CSR_N-1:0] csr_err;
  logic [NG-1:0]    busy;
  logic [CSR_N-1:0] csr_busy;
  logic             gpr_hz, csr_hz, issue_fire;
  logic             sb_err_q, sb_err_d;

  // A pending write is invisible to a reader when its last copy retires this cycle.
  function automatic logic src_blocked(input logic [CNT_W-1:0] c, input logic [1:0] d);
    return (c != '0) && !((WB_BYPASS != 0) && (c == CNT_ONE) && (d != 2'd0));
  endfunction

  assign gpr_cnt[0] = '0;
  assign gpr_dec[0] = 2'd0;
  assign gpr_err[0] = 1'b0;

  for (genvar r = 1; r < NG; r++) begin : g_gpr
    logic wb_hit, kill_hit, inc;
    assign wb_hit   = sb.wb_valid & sb.wb_R_wen & (sb.wb_rd == 5'(r));
    assign kill_hit = sb.kill_valid & sb.kill_R_wen & (sb.kill_rd == 5'(r));
    assign gpr_dec[r] = {1'b0, wb_hit} + {1'b0, kill_hit};
    assign inc = issue_fire & sb.issue_R_wen & (sb.issue_rd == 5'(r));
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(gpr_dec[r]),
      .cnt(gpr_cnt[r]), .err(gpr_err[r])
    );
  end

  for (genvar l = 0; l < CSR_N; l++) begin : g_csr
    logic inc;
    assign csr_dec[l] = {1'b0, sb.wb_valid & sb.wb_csr_wen[l]}
                      + {1'b0, sb.kill_valid & sb.kill_csr_wen[l]};
    assign inc = issue_fire & sb.issue_csr_wen[l];
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(csr_dec[l]),
      .cnt(csr_cnt[l]), .err(csr_err[l])
    );
  end

  always_comb begin
    gpr_hz = 1'b0;
    if (sb.issue_rs1_used && sb.issue_rs1 != 5'd0 &&
        src_blocked(gpr_cnt[sb.issue_rs1], gpr_dec[sb.issue_rs1])) gpr_hz = 1'b1;
    if (sb.issue_rs2_used && sb.issue_rs2 != 5'd0 &&
        src_blocked(gpr_cnt[sb.issue_rs2], gpr_dec[sb.issue_rs2])) gpr_hz = 1'b1;
    // Full counter only blocks a new write if nothing drains it this cycle.
    if (sb.issue_R_wen && sb.issue_rd != 5'd0 &&
        gpr_cnt[sb.issue_rd] == CNT_MAX && gpr_dec[sb.issue_rd] == 2'd0) gpr_hz = 1'b1;
  end

  always_comb begin
    csr_hz = 1'b0;
    for (int l = 0; l < CSR_N; l++) begin
      if (sb.issue_csr_rmask[l] && src_blocked(csr_cnt[l], csr_dec[l])) csr_hz = 1'b1;
      if (sb.issue_csr_wen[l] && csr_cnt[l] == CNT_MAX && csr_dec[l] == 2'd0) csr_hz = 1'b1;
    end
  end

  assign sb.issue_ready = !(gpr_hz || csr_hz);
  assign issue_fire     = sb.issue_valid & sb.issue_ready;

  always_comb begin
    busy = '0;
    for (int r = 0; r < NG; r++) busy[r] = (gpr_cnt[r] != '0);
    csr_busy = '0;
    for (int l = 0; l < CSR_N; l++) csr_busy[l] = (csr_cnt[l] != '0);
  end

  assign sb_err_d = sb_err_q | (|gpr_err) | (|csr_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_err_q <= 1'b0;
    else        sb_err_q <= sb_err_d;
  end

  assign sb.busy_mask = busy;
  assign sb.csr_busy  = csr_busy;
  assign sb.sb_err    = sb_err_q;
endmodule
